goomba_spawner: RTL and testbench
=================================

GOOMBA_SPAWNER -- requirements
Module: goomba_spawner

Interface
REQ-001 Parameter NUM_SLOTS, default 4, SHALL set the number of goomba instances managed; the start, kill and isAlive buses are NUM_SLOTS wide.
REQ-002 Parameter SPAWN_X, default 10'd500, SHALL set the X spawn coordinate for every table entry.
REQ-003 Clk  input  1  system clock; the only clock in the block.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 frame_clk  input  1  vertical-sync frame tick; the block uses its rising edge.
REQ-006 Shift  input  1  screen-scroll request; sampled on the frame edge; one Shift equals one 40-pixel column.
REQ-007 level_reset  input  1  level restart request; sampled every Clk.
REQ-008 isAlive  input  NUM_SLOTS  per-slot goomba alive flag.
REQ-009 start  output  NUM_SLOTS  one-cycle per-slot spawn pulse.
REQ-010 kill  output  NUM_SLOTS  one-cycle per-slot despawn pulse.
REQ-011 spawnX, spawnY  output  10 each  spawn coordinates; spawnY is the ground line of the goomba's feet.
REQ-012 scroll_col  output  8  current scroll column.
REQ-013 all_spawned  output  1  high once all 8 table entries have been issued.

Function
REQ-014 Frame edge detection SHALL use a registered delay: frame_edge is high for exactly one Clk, one cycle after frame_clk rises.
REQ-015 The spawn table SHALL be a fixed 8-entry ROM of {col, Y}:
- cols: 2, 5, 6, 10, 14, 15, 20, 27.
- Y: 439 for all entries except entries 3 and 6, which use 359.
REQ-016 scroll_col SHALL increment by 1 on a frame_edge cycle when Shift=1, and SHALL saturate at 255.
REQ-017 Comparisons SHALL use the pre-increment scroll_col, so a new column takes effect at the next frame_edge.
REQ-018 The FSM SHALL have states IDLE, CHECK, SPAWN and WAIT.
REQ-019 IDLE -> CHECK SHALL occur on frame_edge when all_spawned=0 and table[ptr].col <= scroll_col; otherwise the FSM SHALL stay in IDLE.
REQ-020 In CHECK, the block SHALL select the lowest-index slot with isAlive=0 and go to SPAWN.
REQ-021 In CHECK, if every slot has isAlive=1, the FSM SHALL return to IDLE with ptr unchanged (the entry stays pending and is retried at the next frame_edge).
REQ-022 In SPAWN, the block SHALL, in the same cycle:
- assert start[slot] for exactly one cycle;
- drive spawnX=SPAWN_X and spawnY=table[ptr].Y;
- increment ptr, setting all_spawned=1 when ptr was 7;
- go to WAIT.
REQ-023 WAIT SHALL last exactly one cycle and then go to IDLE, giving at most one spawn per frame.
REQ-024 spawnX and spawnY SHALL hold their last driven values outside SPAWN.
REQ-025 At most one start bit SHALL be high in any cycle; start and kill SHALL never be high in the same cycle.
REQ-026 When level_reset=1, in the following cycle the block SHALL:
- assert kill=all ones for one cycle;
- clear scroll_col, ptr and all_spawned;
- enter IDLE, regardless of state; a SPAWN in progress is aborted, with no start asserted in that cycle.
REQ-027 Reset SHALL take priority over level_reset; kill SHALL NOT be asserted because of Reset.
REQ-028 A frame_edge that coincides with level_reset SHALL be ignored.
REQ-029 Multiple due entries (e.g. cols 5 and 6) SHALL issue on consecutive frames, in table order.

Reset
REQ-030 On Reset=1, every output (start, kill, spawnX, spawnY, scroll_col, all_spawned) SHALL be 0 at the next Clk edge.
REQ-031 On Reset=1, state SHALL be IDLE, ptr SHALL be 0 and the frame_clk delay register SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL override every transition in progress.

Verification
REQ-033 Reset held 3 cycles -> all outputs 0; no start for 10 frames with Shift=0.
REQ-034 Shift=1 for 2 frames, then 1 frame with Shift=0, isAlive=0000 -> start=0001 for exactly one Clk, spawnX=500, spawnY=439.
REQ-035 Entry due with isAlive=0111 -> start=1000; with isAlive=1111 -> no start; isAlive[1] drops -> start=0010 on the next frame.
REQ-036 level_reset during WAIT -> next cycle kill=1111 for one Clk, scroll_col=0, no start; the first entry reissues after 2 more Shift frames.
REQ-037 Shift held for 30 frames with slots always free -> 8 starts, one per frame, entry 3 with spawnY=359; all_spawned=1; no further starts.
REQ-038 Shift held 260 frames -> scroll_col=255, with no wrap.

Source files
------------

// File: rtl/goomba_spawner.sv
// Goomba spawner: walks a fixed 8-entry spawn table as the screen scrolls and
// issues at most one spawn per frame into the lowest free goomba slot.
module goomba_spawner #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter logic [9:0]  SPAWN_X   = 10'd500
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic                 Shift,
  input  logic                 level_reset,
  input  logic [NUM_SLOTS-1:0] isAlive,
  output logic [NUM_SLOTS-1:0] start,
  output logic [NUM_SLOTS-1:0] kill,
  output logic [9:0]           spawnX,
  output logic [9:0]           spawnY,
  output logic [7:0]           scroll_col,
  output logic                 all_spawned
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_SPAWN = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam int unsigned PTR_W = 3;
  localparam int unsigned COL_W = 8;
  localparam int unsigned POS_W = 10;

  logic [1:0]           state, state_d;
  logic                 frame_prev;
  logic [PTR_W-1:0]     ptr, ptr_d;
  logic                 done_d;
  logic [COL_W-1:0]     scroll_d;
  logic [NUM_SLOTS-1:0] start_d, kill_d;
  logic [POS_W-1:0]     spawn_x_d, spawn_y_d;
  logic                 frame_edge_c;
  logic [NUM_SLOTS-1:0] lowest_free_c;

  // Spawn table column lookup
  function automatic logic [COL_W-1:0] rom_col(input logic [PTR_W-1:0] idx);
    case (idx)
      3'd0:    rom_col = 8'd2;
      3'd1:    rom_col = 8'd5;
      3'd2:    rom_col = 8'd6;
      3'd3:    rom_col = 8'd10;
      3'd4:    rom_col = 8'd14;
      3'd5:    rom_col = 8'd15;
      3'd6:    rom_col = 8'd20;
      default: rom_col = 8'd27;
    endcase
  endfunction

  // Spawn table ground-line lookup; entries 3 and 6 sit on raised platforms
  function automatic logic [POS_W-1:0] rom_y(input logic [PTR_W-1:0] idx);
    if (idx == 3'd3 || idx == 3'd6) rom_y = 10'd359;
    else                            rom_y = 10'd439;
  endfunction

  // Rising edge of the frame tick against its one-cycle delayed copy
  assign frame_edge_c = frame_clk & ~frame_prev;

  // Lowest clear bit of isAlive as a one-hot vector; zero when all slots busy
  assign lowest_free_c = ~isAlive & (isAlive + NUM_SLOTS'(1));

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    done_d    = all_spawned;
    scroll_d  = scroll_col;
    start_d   = '0;
    kill_d    = '0;
    spawn_x_d = spawnX;
    spawn_y_d = spawnY;

    if (level_reset) begin
      kill_d   = '1;
      scroll_d = '0;
      ptr_d    = '0;
      done_d   = 1'b0;
      state_d  = S_IDLE;
    end else begin
      if (frame_edge_c && Shift && scroll_col != 8'hFF)
        scroll_d = scroll_col + 8'd1;

      case (state)
        S_IDLE: begin
          if (frame_edge_c && !all_spawned && rom_col(ptr) <= scroll_col)
            state_d = S_CHECK;
        end
        S_CHECK: begin
          if (lowest_free_c != '0) begin
            state_d   = S_SPAWN;
            start_d   = lowest_free_c;
            spawn_x_d = SPAWN_X;
            spawn_y_d = rom_y(ptr);
            ptr_d     = ptr + 3'd1;
            if (ptr == 3'd7) done_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SPAWN: state_d = S_WAIT;
        S_WAIT:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      frame_prev  <= 1'b0;
      ptr         <= '0;
      all_spawned <= 1'b0;
      scroll_col  <= '0;
      start       <= '0;
      kill        <= '0;
      spawnX      <= '0;
      spawnY      <= '0;
    end else begin
      state       <= state_d;
      frame_prev  <= frame_clk;
      ptr         <= ptr_d;
      all_spawned <= done_d;
      scroll_col  <= scroll_d;
      start       <= start_d;
      kill        <= kill_d;
      spawnX      <= spawn_x_d;
      spawnY      <= spawn_y_d;
    end
  end

endmodule

// File: tb/tb_goomba_spawner.sv
// Self-checking bench for goomba_spawner against a frame-level reference model.
module tb_goomba_spawner;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       Shift = 1'b0;
  logic       level_reset = 1'b0;
  logic [3:0] isAlive = 4'b0000;
  logic [3:0] start, kill;
  logic [9:0] spawnX, spawnY;
  logic [7:0] scroll_col;
  logic       all_spawned;

  int errors = 0;
  int checks = 0;
  int tot_starts = 0;

  // Reference model state (frame granularity)
  int col_tab [8] = '{2, 5, 6, 10, 14, 15, 20, 27};
  int y_tab   [8] = '{439, 439, 439, 359, 439, 439, 359, 439};
  int m_scroll, m_ptr, m_last_x, m_last_y;
  bit m_done;

  goomba_spawner #(.NUM_SLOTS(4), .SPAWN_X(10'd500)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Shift(Shift),
    .level_reset(level_reset), .isAlive(isAlive), .start(start), .kill(kill),
    .spawnX(spawnX), .spawnY(spawnY), .scroll_col(scroll_col),
    .all_spawned(all_spawned)
  );

  always #5 Clk = ~Clk;

  task automatic model_level_clear();
    m_scroll = 0; m_ptr = 0; m_done = 0;
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1; level_reset = 1'b0; frame_clk = 1'b0; Shift = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    model_level_clear();
    m_last_x = 0; m_last_y = 0;
    @(negedge Clk);
  endtask

  // One frame: raise frame_clk, watch 10 cycles, compare with the model
  task automatic do_frame(input bit sh, input logic [3:0] alive);
    logic [3:0] exp_start, got_start;
    int exp_n, got_n, bad, got_x, got_y;
    exp_start = 4'b0000;
    if (!m_done && col_tab[m_ptr] <= m_scroll) begin
      for (int i = 0; i < 4; i++)
        if (!alive[i] && exp_start == 4'b0000) exp_start = 4'(1 << i);
      if (exp_start != 4'b0000) begin
        m_last_x = 500; m_last_y = y_tab[m_ptr];
        m_ptr++;
        if (m_ptr == 8) m_done = 1;
      end
    end
    if (sh && m_scroll < 255) m_scroll++;
    exp_n = (exp_start != 4'b0000) ? 1 : 0;

    Shift = sh; isAlive = alive; frame_clk = 1'b1;
    got_n = 0; bad = 0; got_start = 4'b0000; got_x = 0; got_y = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (i == 4) frame_clk = 1'b0;
      if (kill !== 4'b0000) bad++;
      if (start !== 4'b0000) begin
        got_n++;
        got_start = start; got_x = int'(spawnX); got_y = int'(spawnY);
        if ($countones(start) != 1) bad++;
      end
    end
    tot_starts += got_n;

    checks++;
    if (bad !== 0) begin errors++; $display("FAIL frame_glitch: bad_cycles=%0d expected 0", bad); end
    checks++;
    if (got_n !== exp_n) begin errors++; $display("FAIL start_count: got %0d expected %0d", got_n, exp_n); end
    if (exp_n == 1 && got_n == 1) begin
      checks++;
      if (got_start !== exp_start) begin errors++; $display("FAIL start_slot: got %b expected %b", got_start, exp_start); end
      checks++;
      if (got_x !== 500) begin errors++; $display("FAIL spawnX: got %0d expected 500", got_x); end
      checks++;
      if (got_y !== m_last_y) begin errors++; $display("FAIL spawnY: got %0d expected %0d", got_y, m_last_y); end
    end
    checks++;
    if (int'(spawnY) !== m_last_y || int'(spawnX) !== m_last_x) begin
      errors++; $display("FAIL spawn_hold: got x=%0d y=%0d expected x=%0d y=%0d", spawnX, spawnY, m_last_x, m_last_y);
    end
    checks++;
    if (int'(scroll_col) !== m_scroll) begin errors++; $display("FAIL scroll_col: got %0d expected %0d", scroll_col, m_scroll); end
    checks++;
    if (all_spawned !== m_done) begin errors++; $display("FAIL all_spawned: got %0b expected %0b", all_spawned, m_done); end
  endtask

  task automatic pulse_level_reset();
    @(negedge Clk);
    level_reset = 1'b1;
    @(negedge Clk);
    level_reset = 1'b0;
    checks++;
    if (kill !== 4'b1111 || start !== 4'b0000) begin
      errors++; $display("FAIL lr_kill: got kill=%b start=%b expected 1111/0000", kill, start);
    end
    model_level_clear();
    @(negedge Clk);
    checks++;
    if (kill !== 4'b0000 || scroll_col !== 8'd0 || all_spawned !== 1'b0) begin
      errors++; $display("FAIL lr_after: got kill=%b scroll=%0d done=%b expected 0000/0/0", kill, scroll_col, all_spawned);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (start !== 4'b0 || kill !== 4'b0 || spawnX !== 10'd0 || spawnY !== 10'd0 ||
        scroll_col !== 8'd0 || all_spawned !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got start=%b kill=%b x=%0d y=%0d col=%0d done=%b expected all 0",
                         start, kill, spawnX, spawnY, scroll_col, all_spawned);
    end
    Reset = 1'b0;
    model_level_clear(); m_last_x = 0; m_last_y = 0;
    @(negedge Clk);
    for (int f = 0; f < 10; f++) do_frame(1'b0, 4'b0000);
  endtask

  task automatic test_first_spawn();
    apply_reset();
    do_frame(1'b1, 4'b0000);
    do_frame(1'b1, 4'b0000);
    do_frame(1'b0, 4'b0000);
  endtask

  task automatic test_slot_select();
    apply_reset();
    do_frame(1'b1, 4'b1111);
    do_frame(1'b1, 4'b1111);
    do_frame(1'b0, 4'b0111);
    for (int f = 0; f < 4; f++) do_frame(1'b1, 4'b1111);
    do_frame(1'b0, 4'b1101);
  endtask

  task automatic test_level_reset_wait();
    bit seen;
    apply_reset();
    do_frame(1'b1, 4'b0000);
    do_frame(1'b1, 4'b0000);
    Shift = 1'b0; isAlive = 4'b0000; frame_clk = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clk);
      if (start !== 4'b0000) seen = 1;
    end
    checks++;
    if (!seen || start !== 4'b0001) begin
      errors++; $display("FAIL wait_spawn: got seen=%0b start=%b expected 1/0001", seen, start);
    end
    @(negedge Clk);
    level_reset = 1'b1;
    @(negedge Clk);
    level_reset = 1'b0;
    checks++;
    if (kill !== 4'b1111 || start !== 4'b0000 || scroll_col !== 8'd0 || all_spawned !== 1'b0) begin
      errors++; $display("FAIL wait_lr: got kill=%b start=%b col=%0d expected 1111/0000/0", kill, start, scroll_col);
    end
    @(negedge Clk);
    checks++;
    if (kill !== 4'b0000) begin errors++; $display("FAIL wait_lr_pulse: got kill=%b expected 0000", kill); end
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    model_level_clear(); m_last_x = 500; m_last_y = 439;
    do_frame(1'b1, 4'b0000);
    do_frame(1'b1, 4'b0000);
    do_frame(1'b0, 4'b0000);
  endtask

  task automatic test_reset_midop();
    int n;
    apply_reset();
    do_frame(1'b1, 4'b0000);
    do_frame(1'b1, 4'b0000);
    Shift = 1'b0; isAlive = 4'b0000; frame_clk = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (start !== 4'b0000 || kill !== 4'b0000) n++;
      if (i == 2) frame_clk = 1'b0;
      @(negedge Clk);
    end
    checks++;
    if (n !== 0 || scroll_col !== 8'd0) begin
      errors++; $display("FAIL reset_midop: got pulses=%0d col=%0d expected 0/0", n, scroll_col);
    end
    model_level_clear(); m_last_x = 0; m_last_y = 0;
  endtask

  task automatic test_full_table();
    apply_reset();
    tot_starts = 0;
    for (int f = 0; f < 30; f++) do_frame(1'b1, 4'b0000);
    checks++;
    if (tot_starts !== 8) begin errors++; $display("FAIL table_starts: got %0d expected 8", tot_starts); end
    checks++;
    if (all_spawned !== 1'b1) begin errors++; $display("FAIL table_done: got %b expected 1", all_spawned); end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int f = 0; f < 260; f++) do_frame(1'b1, 4'b0000);
    checks++;
    if (scroll_col !== 8'd255) begin errors++; $display("FAIL saturate: got %0d expected 255", scroll_col); end
  endtask

  task automatic test_random();
    logic [3:0] a;
    apply_reset();
    for (int f = 0; f < 120; f++) begin
      if ($urandom_range(0, 24) == 0) pulse_level_reset();
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = 4'b1111;
      do_frame($urandom_range(0, 3) != 0, a);
    end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_slot_select();
    test_level_reset_wait();
    test_reset_midop();
    test_full_table();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
